// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the CPU/video data-RAM port arbiter.
package ram_port_arbiter_pkg;

  localparam int AW_DEFAULT = 15;
  localparam int DW_DEFAULT = 32;
  localparam int BE_W       = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CPU_WR = 3'd1,
    CPU_RA = 3'd2,
    CPU_RD = 3'd3,
    VID_RA = 3'd4,
    VID_RD = 3'd5
  } state_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the CPU, video and RAM-side signals around the arbiter.
interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
);

  logic            cpu_req;
  logic [BE_W-1:0] cpu_we;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata;
  logic            cpu_ack;
  logic [DW-1:0]   cpu_rdata;

  logic            vid_req;
  logic [AW-1:0]   vid_addr;
  logic            vid_ack;
  logic [DW-1:0]   vid_rdata;

  logic [AW-1:0]   mem_addr;
  logic [BE_W-1:0] mem_we;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  logic            busy;

  // Requesters and RAM side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
    input  cpu_ack, cpu_rdata, vid_ack, vid_rdata, mem_addr, mem_we, mem_wdata, busy
  );

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
    output cpu_ack, cpu_rdata, vid_ack, vid_rdata, mem_addr, mem_we, mem_wdata, busy
  );

endinterface

// File: rtl/ram_port_arbiter_starve_counter.sv
// Counts consecutive video wins taken while the CPU was waiting; sat forces a CPU win.
module starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_r;

  // Saturating counter; a clear always takes priority over an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != MAX_C)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign sat = (cnt_r == MAX_C);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous-read data RAM between the CPU data port and the VGA text fetch.
// Video wins ties until the CPU has been starved STARVE_MAX times in a row.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEFAULT,
  parameter int DW         = DW_DEFAULT,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  ram_port_arbiter_if.slave bus
);

  state_t          state_r;
  logic            cpu_ack_r;
  logic            vid_ack_r;
  logic            busy_r;
  logic [AW-1:0]   mem_addr_r;
  logic [BE_W-1:0] mem_we_r;
  logic [DW-1:0]   mem_wdata_r;
  logic [DW-1:0]   cpu_rdata_r;
  logic [DW-1:0]   vid_rdata_r;

  logic cpu_win_s;
  logic vid_win_s;
  logic starve_sat_s;
  logic starve_inc_s;
  logic starve_clr_s;

  // Grant decision, only meaningful while IDLE.
  always_comb begin
    cpu_win_s = 1'b0;
    vid_win_s = 1'b0;
    if (state_r == IDLE) begin
      cpu_win_s = bus.cpu_req && (!bus.vid_req || starve_sat_s);
      vid_win_s = bus.vid_req && !cpu_win_s;
    end else begin
      cpu_win_s = 1'b0;
      vid_win_s = 1'b0;
    end
  end

  assign starve_inc_s = vid_win_s && bus.cpu_req;
  assign starve_clr_s = cpu_win_s;

  starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc_s),
    .clr (starve_clr_s),
    .sat (starve_sat_s)
  );

  // Transaction FSM; acks are set on entry to their state so they track it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cpu_ack_r   <= 1'b0;
      vid_ack_r   <= 1'b0;
      busy_r      <= 1'b0;
      mem_addr_r  <= '0;
      mem_we_r    <= '0;
      mem_wdata_r <= '0;
      cpu_rdata_r <= '0;
      vid_rdata_r <= '0;
    end else begin
      cpu_ack_r <= 1'b0;
      vid_ack_r <= 1'b0;
      mem_we_r  <= '0;
      case (state_r)
        IDLE: begin
          if (cpu_win_s) begin
            mem_addr_r <= bus.cpu_addr;
            busy_r     <= 1'b1;
            if (|bus.cpu_we) begin
              mem_we_r    <= bus.cpu_we;
              mem_wdata_r <= bus.cpu_wdata;
              cpu_ack_r   <= 1'b1;
              state_r     <= CPU_WR;
            end else begin
              state_r <= CPU_RA;
            end
          end else if (vid_win_s) begin
            mem_addr_r <= bus.vid_addr;
            busy_r     <= 1'b1;
            state_r    <= VID_RA;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        CPU_WR: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        CPU_RA: begin
          cpu_ack_r <= 1'b1;
          state_r   <= CPU_RD;
        end
        CPU_RD: begin
          cpu_rdata_r <= bus.mem_rdata;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        VID_RA: begin
          vid_ack_r <= 1'b1;
          state_r   <= VID_RD;
        end
        VID_RD: begin
          vid_rdata_r <= bus.mem_rdata;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // RAM data only arrives in the ack cycle, so it is passed through then and held after.
  assign bus.cpu_rdata = cpu_ack_r ? bus.mem_rdata : cpu_rdata_r;
  assign bus.vid_rdata = vid_ack_r ? bus.mem_rdata : vid_rdata_r;
  assign bus.cpu_ack   = cpu_ack_r;
  assign bus.vid_ack   = vid_ack_r;
  assign bus.busy      = busy_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a 1-cycle synchronous RAM model.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int AW = 15;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  int   proto_err = 0;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] ram [0:(1<<AW)-1];

  // Byte-enabled RAM, read data valid one clock after the address.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Protocol monitor: never both acks, writes only in CPU_WR.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cpu_ack && bus.vid_ack) proto_err++;
      if ((bus.mem_we != 4'h0) && (dut.state_r != CPU_WR)) proto_err++;
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (dut.state_r !== IDLE) $display("FAIL reset_state: got %0d want %0d", dut.state_r, IDLE); else passes++;
    checks++;
    if ({bus.cpu_ack, bus.vid_ack, bus.busy, bus.mem_we} !== 7'h00)
      $display("FAIL reset_ctrl: got %h want 00", {bus.cpu_ack, bus.vid_ack, bus.busy, bus.mem_we});
    else passes++;
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.vid_rdata} !== {AW'(0), 96'h0})
      $display("FAIL reset_data: got %h want 0", {bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.vid_rdata});
    else passes++;
    checks++; if (dut.u_starve.cnt_r !== 3'd0) $display("FAIL reset_starve: got %0d want 0", dut.u_starve.cnt_r); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_cpu_write;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 4'hF; bus.cpu_addr = 15'h0010; bus.cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (bus.cpu_ack !== 1'b1) $display("FAIL wr_ack: got %b want 1", bus.cpu_ack); else passes++;
    checks++; if (bus.mem_we !== 4'hF) $display("FAIL wr_mem_we: got %h want f", bus.mem_we); else passes++;
    checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== {15'h0010, 32'hDEADBEEF})
      $display("FAIL wr_mem_bus: got %h/%h want 0010/deadbeef", bus.mem_addr, bus.mem_wdata);
    else passes++;
    bus.cpu_req = 1'b0; bus.cpu_we = 4'h0; bus.cpu_addr = 15'h0055; bus.cpu_wdata = 32'h0;
    @(negedge clk);
    checks++;
    if ({bus.cpu_ack, bus.mem_we, bus.busy} !== 6'b0)
      $display("FAIL wr_done: ack/we/busy got %b/%h/%b want 0/0/0", bus.cpu_ack, bus.mem_we, bus.busy);
    else passes++;
    checks++; if (ram[16] !== 32'hDEADBEEF) $display("FAIL wr_ram: got %h want deadbeef", ram[16]); else passes++;
  endtask

  task automatic test_byte_write_read;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 4'b0010; bus.cpu_addr = 15'h0010; bus.cpu_wdata = 32'h0000AB00;
    @(negedge clk);
    checks++; if (bus.mem_we !== 4'b0010) $display("FAIL bw_mem_we: got %b want 0010", bus.mem_we); else passes++;
    bus.cpu_req = 1'b0; bus.cpu_we = 4'h0;
    @(negedge clk);
    checks++; if (ram[16] !== 32'hDEADABEF) $display("FAIL bw_ram: got %h want deadabef", ram[16]); else passes++;
    bus.cpu_req = 1'b1; bus.cpu_addr = 15'h0010;
    @(negedge clk);
    checks++;
    if ({bus.cpu_ack, bus.busy} !== 2'b01) $display("FAIL rd_setup: ack/busy got %b/%b want 0/1", bus.cpu_ack, bus.busy);
    else passes++;
    bus.cpu_addr = 15'h0020;
    @(negedge clk);
    checks++; if (bus.cpu_ack !== 1'b1) $display("FAIL rd_ack_cycle3: got %b want 1", bus.cpu_ack); else passes++;
    checks++; if (bus.cpu_rdata !== 32'hDEADABEF) $display("FAIL rd_data: got %h want deadabef", bus.cpu_rdata); else passes++;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b0, 32'hDEADABEF})
      $display("FAIL rd_hold: ack/data got %b/%h want 0/deadabef", bus.cpu_ack, bus.cpu_rdata);
    else passes++;
  endtask

  task automatic test_simultaneous;
    int vid_at, cpu_at, vid_n, cpu_n;
    logic [DW-1:0] vdata, cdata;
    vid_at = -1; cpu_at = -1; vid_n = 0; cpu_n = 0; vdata = '0; cdata = '0;
    // Top word, exercising the last address before wrap.
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 4'hF; bus.cpu_addr = 15'h7FFF; bus.cpu_wdata = 32'h12345678;
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.cpu_we = 4'h0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_addr = 15'h7FFF;
    bus.vid_req = 1'b1; bus.vid_addr = 15'h0010;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.vid_ack) begin
        if (vid_at < 0) vid_at = c;
        vid_n++; vdata = bus.vid_rdata; bus.vid_req = 1'b0;
      end
      if (bus.cpu_ack) begin
        if (cpu_at < 0) cpu_at = c;
        cpu_n++; cdata = bus.cpu_rdata; bus.cpu_req = 1'b0;
      end
    end
    checks++; if (vid_at !== 2) $display("FAIL sim_vid_first: vid ack cycle got %0d want 2", vid_at); else passes++;
    checks++; if (cpu_at !== 5) $display("FAIL sim_cpu_after: cpu ack cycle got %0d want 5", cpu_at); else passes++;
    checks++; if ({vid_n, cpu_n} !== {32'd1, 32'd1}) $display("FAIL sim_ack_count: vid/cpu got %0d/%0d want 1/1", vid_n, cpu_n); else passes++;
    checks++; if (vdata !== 32'hDEADABEF) $display("FAIL sim_vid_data: got %h want deadabef", vdata); else passes++;
    checks++; if (cdata !== 32'h12345678) $display("FAIL sim_cpu_data: got %h want 12345678", cdata); else passes++;
  endtask

  task automatic test_starvation;
    logic [10:0] grants, exp_grants;
    int n, off, c_first, c_second;
    grants = '0; exp_grants = 11'b10000_010000; n = 0; off = 0; c_first = -1; c_second = -1;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 4'h0; bus.cpu_addr = 15'h0010;
    bus.vid_req = 1'b1; bus.vid_addr = 15'h0010;
    for (int cyc = 1; cyc <= 100 && n < 11; cyc++) begin
      @(negedge clk);
      if (off > 0) begin
        off--;
        if (off == 0) bus.cpu_req = 1'b1;
      end
      if (bus.cpu_ack) begin
        grants[n] = 1'b1;
        n++;
        if (c_first < 0) c_first = cyc; else c_second = cyc;
        checks++; if (dut.u_starve.cnt_r !== 3'd0) $display("FAIL starve_clr: got %0d want 0", dut.u_starve.cnt_r); else passes++;
        bus.cpu_req = 1'b0; off = 2;
      end else if (bus.vid_ack) begin
        if (n == 3) begin
          checks++; if (dut.u_starve.cnt_r !== 3'd4) $display("FAIL starve_sat: got %0d want 4", dut.u_starve.cnt_r); else passes++;
        end
        n++;
      end
    end
    bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
    checks++; if (n !== 11) $display("FAIL starve_grants: got %0d grants want 11", n); else passes++;
    checks++; if (grants !== exp_grants) $display("FAIL starve_order: got %b want %b", grants, exp_grants); else passes++;
    checks++; if ({c_first, c_second} !== {32'd14, 32'd32}) $display("FAIL starve_period: cpu acks got %0d/%0d want 14/32", c_first, c_second); else passes++;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL starve_idle: busy got %b want 0", bus.busy); else passes++;
  endtask

  task automatic test_reset_mid_read;
    int ack_at, ack_n;
    ack_at = -1; ack_n = 0;
    @(negedge clk);
    bus.vid_req = 1'b1; bus.vid_addr = 15'h0010;
    @(negedge clk);
    checks++; if (dut.state_r !== VID_RA) $display("FAIL rr_in_vid_ra: state got %0d want %0d", dut.state_r, VID_RA); else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.vid_ack, bus.cpu_ack, bus.busy, bus.mem_we} !== 7'h00)
      $display("FAIL rr_ctrl: got %h want 00", {bus.vid_ack, bus.cpu_ack, bus.busy, bus.mem_we});
    else passes++;
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.vid_rdata} !== {AW'(0), 96'h0})
      $display("FAIL rr_data: got %h want 0", {bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.vid_rdata});
    else passes++;
    @(negedge clk);
    checks++; if (bus.vid_ack !== 1'b0) $display("FAIL rr_no_ack: got %b want 0", bus.vid_ack); else passes++;
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.vid_ack) begin
        if (ack_at < 0) ack_at = c;
        ack_n++;
        checks++; if (bus.vid_rdata !== 32'hDEADABEF) $display("FAIL rr_data_after: got %h want deadabef", bus.vid_rdata); else passes++;
        bus.vid_req = 1'b0;
      end
    end
    checks++; if (ack_at !== 2) $display("FAIL rr_ack_cycle3: got %0d want 2", ack_at); else passes++;
    checks++; if (ack_n !== 1) $display("FAIL rr_ack_once: got %0d want 1", ack_n); else passes++;
  endtask

  task automatic test_protocol;
    checks++; if (proto_err !== 0) $display("FAIL protocol: violations got %0d want 0", proto_err); else passes++;
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 4'h0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    rst = 1'b1;
    test_reset();
    test_cpu_write();
    test_byte_write_read();
    test_simultaneous();
    test_starvation();
    test_reset_mid_read();
    test_protocol();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter AW, default 15, word-address width of the shared data RAM.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter STARVE_MAX, default 4, number of consecutive video wins after which the CPU is forced to win.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cpu_req  input  1  CPU data-port request; held high until cpu_ack.
REQ-007 cpu_we  input  4  CPU byte-write enables; nonzero = write, zero = read.
REQ-008 cpu_addr  input  AW  CPU word address.
REQ-009 cpu_wdata  input  DW  CPU write data.
REQ-010 cpu_ack  output  1  one-cycle completion pulse for the CPU.
REQ-011 cpu_rdata  output  DW  CPU read data, valid while cpu_ack is high for a read, held afterwards.
REQ-012 vid_req  input  1  VGA text-fetch request; held high until vid_ack.
REQ-013 vid_addr  input  AW  VGA character-cell word address.
REQ-014 vid_ack  output  1  one-cycle completion pulse for video.
REQ-015 vid_rdata  output  DW  video read data, valid while vid_ack is high, held afterwards.
REQ-016 mem_addr  output  AW  RAM address, registered.
REQ-017 mem_we  output  4  RAM byte-write enables, registered.
REQ-018 mem_wdata  output  DW  RAM write data, registered.
REQ-019 mem_rdata  input  DW  RAM read data, valid one clock after mem_addr is presented.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, CPU_WR, CPU_RA, CPU_RD, VID_RA and VID_RD.
REQ-022 In IDLE with no request pending, the FSM SHALL stay in IDLE, and mem_we SHALL be 0.
REQ-023 In IDLE, a video win SHALL load mem_addr=vid_addr and go to VID_RA.
REQ-024 In IDLE, a CPU win with nonzero cpu_we SHALL load mem_addr, mem_we=cpu_we and mem_wdata, and go to CPU_WR.
REQ-025 In IDLE, a CPU win with zero cpu_we SHALL load mem_addr=cpu_addr and go to CPU_RA.
REQ-026 CPU_WR: cpu_ack=1, and the FSM goes to IDLE. mem_we SHALL be nonzero only in CPU_WR, so each write lasts exactly one cycle.
REQ-027 CPU_RA goes to CPU_RD, and VID_RA goes to VID_RD; these are the address-setup cycles.
REQ-028 CPU_RD: cpu_rdata<=mem_rdata, cpu_ack=1, and the FSM goes to IDLE.
REQ-029 VID_RD: vid_rdata<=mem_rdata, vid_ack=1, and the FSM goes to IDLE.
REQ-030 Latency, counted from the IDLE cycle in which the request is sampled:
- write: ack in the next cycle (2 cycles total);
- read: ack on the 3rd cycle.
REQ-031 Arbitration SHALL occur only in IDLE; a request raised while busy SHALL wait for IDLE.
REQ-032 When only one requester is active in IDLE, it SHALL win.
REQ-033 When both requesters are active in IDLE, video SHALL win unless starve_cnt==STARVE_MAX, in which case the CPU SHALL win.
REQ-034 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment when video wins while cpu_req=1, and SHALL saturate at STARVE_MAX.
REQ-035 starve_cnt SHALL clear to 0 on every CPU win.
REQ-036 Acks SHALL be Moore outputs decoded from state, never combinational from the req inputs.
REQ-037 Requesters drop req in the cycle after ack; the arbiter SHALL return to IDLE in that cycle and therefore SHALL not double-serve a request.
REQ-038 Changes to address or data while a request is being served SHALL be ignored, because they are captured at grant.
REQ-039 The address SHALL wrap naturally at 2^AW; the block performs no range checking.

Reset
REQ-040 On rst, the FSM SHALL go to IDLE immediately, asynchronously.
REQ-041 On rst, the following outputs SHALL be 0: cpu_ack, vid_ack, busy, mem_we, mem_addr, mem_wdata, cpu_rdata, vid_rdata.
REQ-042 On rst, starve_cnt SHALL be 0.
REQ-043 A reset asserted mid-transaction SHALL abort that transaction without an ack. A write aborted in CPU_WR may or may not have reached RAM.
REQ-044 After reset deasserts, arbitration SHALL resume on the first clock edge.

Structure
REQ-045 The shared package SHALL hold the state enum, the AW/DW defaults and the byte-enable width constant (4).
REQ-046 The starvation counter SHALL be one sub-module, starve_counter, with inputs inc and clr, output sat, and parameter MAX; all other logic SHALL be flat.
REQ-047 The RAM model used in test SHALL have synchronous read with 1-cycle latency, matching REQ-019.

Verification
REQ-048 CPU write only: cpu_req=1, cpu_we=4'b1111, addr=0x0010, wdata=0xDEADBEEF → mem_we=4'hF for exactly one cycle, cpu_ack on cycle 2, and RAM[0x10]=0xDEADBEEF.
REQ-049 Byte write then read: write cpu_we=4'b0010, wdata=0x0000AB00 to addr 0x0010, then read addr 0x0010 → cpu_rdata=0xDEADABEF with ack on cycle 3.
REQ-050 Simultaneous single requests: cpu_req and vid_req rise in the same cycle → the video ack comes first, and the CPU ack follows exactly 3 cycles later.
REQ-051 Starvation: vid_req held continuously and cpu_req held → 4 video grants, then the CPU grant, with starve_cnt returning to 0; repeat and check the periodicity.
REQ-052 Reset mid-read: assert rst in state VID_RA → no vid_ack, busy=0, and all outputs 0; then a vid_req completes normally with ack on cycle 3.
REQ-053 Protocol assertions: at most one of cpu_ack/vid_ack is high; mem_we!=0 only in CPU_WR; every req receives exactly one ack.
